fp_add_stream: RTL and testbench
================================

# fp_add_stream

Streaming front/back end for the 32-bit pipelined floating-point adder. It accepts operand pairs over a valid/ready handshake and issues them to the adder one per cycle. It tracks every operation in flight through the adder's fixed, non-stallable latency and captures each result into an output FIFO that drains over a second valid/ready handshake. Credit-based issue guarantees the adder never produces a result the FIFO cannot hold, so the adder needs no stall logic.

## Interface
- LATENCY, 4, cycles from issue (operands sampled at the end of cycle c) to the result being valid on add_result (cycle c+LATENCY); ≥1.
- DEPTH, 8, output FIFO entries; power of two, ≥2; full throughput needs DEPTH ≥ LATENCY+2.
- clk  in  1  clock, all state on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts the pair this cycle.
- in_a  in  32  IEEE-754 SP operand A.
- in_b  in  32  IEEE-754 SP operand B.
- add_go  out  1  issue strobe to the adder (_go).
- add_a  out  32  to adder Number1.
- add_b  out  32  to adder Number2.
- add_result  in  32  from adder Result.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head.
- out_data  out  32  FIFO head (sum).
- busy  out  1  any operation in flight or buffered.

## Operation
- issue = in_valid & in_ready. add_go = issue; add_a/add_b = in_a/in_b when issue, else 0.
- in_ready = !reset & (inflight + occ < DEPTH). It depends only on registered state, never on out_ready or in_valid in the same cycle.
- Tag shift register tag[LATENCY-1:0]: tag[0] <= issue; tag[k] <= tag[k-1]. capture = tag[LATENCY-1]: add_result is written at wr_ptr at the end of that cycle.
- inflight counter (0..LATENCY): +1 on issue, −1 on capture; both together leave it unchanged.
- occ counter (0..DEPTH): +1 on capture, −1 on pop (out_valid & out_ready); both together leave it unchanged.
- FIFO: DEPTH-entry circular buffer. wr_ptr/rd_ptr are log2(DEPTH) bits and wrap naturally modulo DEPTH. out_valid = (occ != 0). out_data = mem[rd_ptr] when out_valid, else 32'h0.
- The credit invariant inflight + occ ≤ DEPTH holds at all times, so capture never finds the FIFO full. Verification asserts this.
- Results leave in issue order. Result bits are passed through untouched; the block does not interpret the floating-point values.
- busy = (inflight != 0) | (occ != 0).

## Timing
- Reset asserted: tag, inflight, occ, wr_ptr, rd_ptr all cleared asynchronously. While reset is high: out_valid=0, out_data=0, in_ready=0, add_go=0, add_a=add_b=0, busy=0.
- First cycle after reset deasserts: in_ready=1.
- Reset mid-operation discards all in-flight and buffered operations. Stale adder outputs are ignored because the tags are cleared.
- Latency with an empty FIFO: issue in cycle c, capture at the end of c+LATENCY, out_valid=1 in cycle c+LATENCY+1 (5 cycles at default).
- A pop frees credit starting the next cycle. With out_ready held high and DEPTH ≥ LATENCY+2, in_ready stays 1 and one result leaves per cycle.
- While out_valid=1 and out_ready=0, out_data is held stable.
- Capture and pop on the same cycle with occ=DEPTH cannot occur: the credit invariant prevents it.
- Capture and pop on the same cycle with occ=1: occ stays 1 and out_valid stays 1. The new head is the captured entry.

## Test plan
- Reset: assert reset mid-cycle asynchronously with in_valid=1 -> in_ready=0, out_valid=0, out_data=0, busy=0 immediately; in_ready=1 the cycle after release.
- Single op: in_a=0x3F800000, in_b=0x3F800000 issued in cycle 0, out_ready=1 -> out_valid=1 only in cycle 5 with out_data=0x40000000; busy=0 from cycle 6.
- Stream: 16 back-to-back pairs (k·1.0 + 1.0, k=1..16), out_ready=1, default parameters -> in_ready never drops; results arrive in order on cycles 5..20, one per cycle.
- Backpressure/wrap: out_ready=0 and in_valid=1 held -> exactly 8 pairs accepted, then in_ready=0 and out_data stable. Release out_ready for 20 cycles with more input -> all results in order with no loss or duplication across pointer wrap; inflight+occ ≤ 8 every cycle.
- Credit boundary: DEPTH=8, out_ready toggling 1/0 every cycle with continuous input -> in_ready follows the credit rule cycle-exactly and no capture occurs when occ=8.
- Reset mid-flight: issue 3 pairs, assert reset 2 cycles later -> none of the 3 results ever appears. A pair issued after release returns the correct sum after exactly 5 cycles.

Source files
------------

// File: rtl/fp_add_stream.sv
// -----------------------------------------------------------------------------
// fp_add_stream
//
// Streaming wrapper around a fixed-latency, non-stallable pipelined 32-bit
// floating-point adder. Operand pairs arrive over a valid/ready handshake and
// are issued to the adder at most one per cycle. A tag shift register follows
// every issued operation through the adder latency, and the result is written
// into an output FIFO that drains over a second valid/ready handshake.
//
// Issue is credit based: a pair is accepted only while
// (operations in flight + FIFO occupancy) < DEPTH. Every issued operation
// therefore already owns a FIFO slot when its result emerges, so the adder
// never has to stall. Result bits pass through untouched.
//
// Parameters
//   LATENCY  adder latency in cycles from issue to result (>= 1)
//   DEPTH    output FIFO entries (power of two, >= 2)
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset, clears all state
//   in_valid    in   operand pair present
//   in_ready    out  pair accepted this cycle (registered state only)
//   in_a, in_b  in   IEEE-754 single-precision operands
//   add_go      out  issue strobe to the adder
//   add_a/add_b out  operands to the adder (zero when not issuing)
//   add_result  in   adder result, valid LATENCY cycles after issue
//   out_valid   out  FIFO head valid
//   out_ready   in   consumer takes the head
//   out_data    out  FIFO head (zero when empty)
//   busy        out  any operation in flight or buffered
// -----------------------------------------------------------------------------
module fp_add_stream #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        add_go,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  // Pointer width and a counter width wide enough that inflight + occ can be
  // summed without overflow.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + LATENCY + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [LATENCY-1:0] r_tag;
  logic [CW-1:0]      r_inflight;
  logic [CW-1:0]      r_occ;
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [31:0]        r_mem [DEPTH];

  logic               w_issue;
  logic               w_capture;
  logic               w_pop;
  logic               w_credit_ok;
  logic [CW-1:0]      w_outstanding;
  logic [CW-1:0]      w_inflight_nxt;
  logic [CW-1:0]      w_occ_nxt;
  logic [LATENCY-1:0] w_tag_nxt;

  // Credit check uses registered counters only, so in_ready never depends
  // combinationally on in_valid or out_ready.
  assign w_outstanding = r_inflight + r_occ;
  assign w_credit_ok   = (w_outstanding < DEPTH_C);
  assign in_ready      = !reset && w_credit_ok;

  assign w_issue   = in_valid && in_ready;
  assign w_capture = r_tag[LATENCY-1];
  assign out_valid = (r_occ != {CW{1'b0}});
  assign w_pop     = out_valid && out_ready;

  assign add_go   = w_issue;
  assign add_a    = w_issue ? in_a : 32'h0000_0000;
  assign add_b    = w_issue ? in_b : 32'h0000_0000;
  assign out_data = out_valid ? r_mem[r_rd_ptr] : 32'h0000_0000;
  assign busy     = (r_inflight != {CW{1'b0}}) || (r_occ != {CW{1'b0}});

  // Tag shift: one bit per adder stage marking a real (issued) operation.
  generate
    if (LATENCY == 1) begin : g_tag_one
      assign w_tag_nxt = w_issue;
    end else begin : g_tag_many
      assign w_tag_nxt = {r_tag[LATENCY-2:0], w_issue};
    end
  endgenerate

  // In-flight count: issue adds one, capture removes one, both cancel.
  always_comb begin
    w_inflight_nxt = r_inflight;
    case ({w_issue, w_capture})
      2'b10:   w_inflight_nxt = r_inflight + CW'(1);
      2'b01:   w_inflight_nxt = r_inflight - CW'(1);
      default: w_inflight_nxt = r_inflight;
    endcase
  end

  // FIFO occupancy: capture adds one, pop removes one, both cancel.
  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_capture, w_pop})
      2'b10:   w_occ_nxt = r_occ + CW'(1);
      2'b01:   w_occ_nxt = r_occ - CW'(1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  // Control state: tags, counters and pointers, all cleared by reset so that
  // results still inside the adder at reset time are never captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag      <= {LATENCY{1'b0}};
      r_inflight <= {CW{1'b0}};
      r_occ      <= {CW{1'b0}};
      r_wr_ptr   <= {PW{1'b0}};
      r_rd_ptr   <= {PW{1'b0}};
    end else begin
      r_tag      <= w_tag_nxt;
      r_inflight <= w_inflight_nxt;
      r_occ      <= w_occ_nxt;
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // FIFO storage: data only, no reset needed since occ gates visibility.
  // The credit rule guarantees the slot at wr_ptr is free on capture.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem[r_wr_ptr] <= add_result;
    end
  end

endmodule

// File: tb/tb_fp_add_stream.sv
module tb_fp_add_stream;

  localparam int LAT = 4;
  localparam int DEP = 8;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        add_go;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int n_pass;
  int n_total;
  int outstanding;
  logic [31:0] exp_q[$];

  // float values 2.0 .. 17.0
  logic [31:0] stream_exp [16] = '{
    32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
    32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000,
    32'h41200000, 32'h41300000, 32'h41400000, 32'h41500000,
    32'h41600000, 32'h41700000, 32'h41800000, 32'h41880000};

  fp_add_stream #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_go(add_go), .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small non-negative integer-valued float helpers for the adder model.
  function automatic int unsigned fp_to_int(input logic [31:0] f);
    logic [31:0] m;
    int e;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'h00, 1'b1, f[22:0]};
    return m >> (23 - e);
  endfunction

  function automatic logic [31:0] int_to_fp(input int unsigned n);
    int p;
    logic [31:0] m;
    if (n == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 32; i++) if (n[i]) p = i;
    m = (n << (23 - p)) & 32'h007FFFFF;
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  // Behavioural pipelined adder: computes every cycle, never stalls, no reset.
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= int_to_fp(fp_to_int(add_a) + fp_to_int(add_b));
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign add_result = pipe[LAT-1];

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({in_ready, out_valid, add_go, busy} !== 4'b0000 || out_data !== 32'h0) begin
      $display("FAIL reset_state: rdy=%b vld=%b go=%b busy=%b data=%h required all 0",
               in_ready, out_valid, add_go, busy, out_data);
    end else n_pass++;
    advance();
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL ready_after_release: got %b required 1", in_ready);
    else n_pass++;
    // Issue two pairs, then assert reset mid-cycle with in_valid still high.
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000;
    advance();
    advance();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_total++;
    if ({in_ready, out_valid, add_go, busy} !== 4'b0000 || out_data !== 32'h0 ||
        add_a !== 32'h0 || add_b !== 32'h0) begin
      $display("FAIL async_reset: rdy=%b vld=%b go=%b busy=%b data=%h a=%h required all 0",
               in_ready, out_valid, add_go, busy, out_data, add_a);
    end else n_pass++;
    advance();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL ready_after_async: got %b required 1", in_ready);
    else n_pass++;
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL stale_after_reset: cycle %0d vld=%b busy=%b required 0", c, out_valid, busy);
      else n_pass++;
    end
    advance();
  endtask

  task automatic test_single_op();
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_total++;
        if (add_go !== 1'b1 || add_a !== 32'h3F800000 || add_b !== 32'h3F800000)
          $display("FAIL single_issue: go=%b a=%h b=%h required 1/3f800000/3f800000", add_go, add_a, add_b);
        else n_pass++;
      end
      n_total++;
      if (out_valid !== (c == 5))
        $display("FAIL single_valid: cycle %0d got %b required %b", c, out_valid, (c == 5));
      else n_pass++;
      n_total++;
      if (out_data !== ((c == 5) ? 32'h40000000 : 32'h0))
        $display("FAIL single_data: cycle %0d got %h required %h", c, out_data,
                 (c == 5) ? 32'h40000000 : 32'h0);
      else n_pass++;
      n_total++;
      if (busy !== (c >= 1 && c <= 5))
        $display("FAIL single_busy: cycle %0d got %b required %b", c, busy, (c >= 1 && c <= 5));
      else n_pass++;
      advance();
      in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0;
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = int_to_fp(1); in_b = 32'h3F800000;
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      if (c < 16) begin
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL stream_ready: cycle %0d got %b required 1", c, in_ready);
        else n_pass++;
      end
      n_total++;
      if (out_valid !== (c >= 5 && c <= 20))
        $display("FAIL stream_valid: cycle %0d got %b required %b", c, out_valid, (c >= 5 && c <= 20));
      else n_pass++;
      if (c >= 5 && c <= 20) begin
        n_total++;
        if (out_data !== stream_exp[c-5])
          $display("FAIL stream_data: cycle %0d got %h required %h", c, out_data, stream_exp[c-5]);
        else n_pass++;
      end
      advance();
      in_valid = (c + 1 < 16);
      in_a = (c + 1 < 16) ? int_to_fp(c + 2) : 32'h0;
    end
    in_valid = 1'b0; in_b = 32'h0;
  endtask

  // mode 0: out_ready low for 15 cycles, then high with input for 20, then drain
  // mode 1: out_ready toggles every cycle with continuous input for 40, then drain
  task automatic credit_run(input int mode, input string name);
    int k;
    int accepted;
    int stop_in;
    logic held;
    logic [31:0] held_data;
    k = 100; accepted = 0; outstanding = 0; held = 1'b0; held_data = 32'h0;
    exp_q.delete();
    stop_in = (mode == 0) ? 35 : 40;
    in_valid = 1'b1; in_a = int_to_fp(k); in_b = 32'h3F800000;
    out_ready = (mode == 0) ? 1'b0 : 1'b1;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      n_total++;
      if (in_ready !== (outstanding < DEP))
        $display("FAIL %s_credit: cycle %0d ready=%b required %b (outstanding %0d)",
                 name, c, in_ready, (outstanding < DEP), outstanding);
      else n_pass++;
      n_total++;
      if (outstanding > DEP)
        $display("FAIL %s_bound: cycle %0d outstanding %0d required <= %0d", name, c, outstanding, DEP);
      else n_pass++;
      if (held && out_valid) begin
        n_total++;
        if (out_data !== held_data)
          $display("FAIL %s_stable: cycle %0d got %h required %h", name, c, out_data, held_data);
        else n_pass++;
      end
      if (!out_valid) begin
        n_total++;
        if (out_data !== 32'h0) $display("FAIL %s_empty_data: cycle %0d got %h required 0", name, c, out_data);
        else n_pass++;
      end
      if (mode == 0 && c == 15) begin
        n_total++;
        if (accepted != DEP) $display("FAIL %s_accept_count: got %0d required %0d", name, accepted, DEP);
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s_extra_result: cycle %0d got %h required none", name, c, out_data);
        end else begin
          if (out_data !== exp_q[0])
            $display("FAIL %s_order: cycle %0d got %h required %h", name, c, out_data, exp_q[0]);
          else n_pass++;
          void'(exp_q.pop_front());
          outstanding--;
        end
      end
      held = out_valid && !out_ready;
      held_data = out_data;
      if (in_valid && in_ready) begin
        exp_q.push_back(int_to_fp(k + 1));
        outstanding++; accepted++; k++;
      end
      advance();
      if (c + 1 >= stop_in && exp_q.size() == 0) break;
      in_valid = (c + 1 < stop_in);
      in_a = int_to_fp(k);
      if (mode == 0) out_ready = (c + 1 >= 15);
      else out_ready = (c + 1 >= stop_in) ? 1'b1 : ((c + 1) % 2 == 0);
    end
    in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0; out_ready = 1'b1;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL %s_drain: %0d results missing required 0", name, exp_q.size());
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL %s_idle: busy=%b required 0", name, busy);
    else n_pass++;
  endtask

  task automatic test_backpressure_wrap();
    credit_run(0, "bp");
  endtask

  task automatic test_credit_boundary();
    credit_run(1, "credit");
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    in_valid = 1'b1; in_b = 32'h3F800000;
    for (int c = 0; c < 3; c++) begin
      in_a = int_to_fp(20 + c);
      advance();
    end
    in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0;
    advance();
    @(negedge clk);
    reset = 1'b1;
    advance();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b0)
        $display("FAIL midflight_discard: cycle %0d vld=%b data=%h required 0", c, out_valid, out_data);
      else n_pass++;
      advance();
    end
    in_valid = 1'b1; in_a = int_to_fp(40); in_b = 32'h3F800000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_total++;
      if (out_valid !== (c == 5) || out_data !== ((c == 5) ? 32'h42240000 : 32'h0))
        $display("FAIL midflight_after: cycle %0d vld=%b data=%h required %b/%h", c, out_valid,
                 out_data, (c == 5), (c == 5) ? 32'h42240000 : 32'h0);
      else n_pass++;
      advance();
      in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; outstanding = 0;
    test_reset();
    test_single_op();
    test_back_to_back();
    test_backpressure_wrap();
    test_credit_boundary();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
